// File: rtl/wb_tlc_tx_arb.sv
// Two-requester TX arbiter in front of the PCIe core TX port: it holds one grant per packet and alternates priority.
// Optional watchdog (macro WB_TLC_TX_ARB_WDT_EN) aborts a packet that never sees tx_end.
module wb_tlc_tx_arb #(
    parameter int c_DATA_WIDTH = 64,
    parameter int c_WDT_CYCLES = 1024
) (
    input  logic                    clk_125,
    input  logic                    rstn,
    input  logic                    req0,
    input  logic                    req1,
    input  logic [c_DATA_WIDTH-1:0] data0,
    input  logic [c_DATA_WIDTH-1:0] data1,
    input  logic                    st0,
    input  logic                    st1,
    input  logic                    end0,
    input  logic                    end1,
    input  logic                    dwen0,
    input  logic                    dwen1,
    output logic                    rdy0,
    output logic                    rdy1,
    output logic                    tx_req,
    input  logic                    tx_rdy,
    input  logic                    tx_val,
    output logic [c_DATA_WIDTH-1:0] tx_data,
    output logic                    tx_st,
    output logic                    tx_end,
    output logic                    tx_dwen,
    output logic                    arb_err,
    output logic [1:0]              dbg_state,
    output logic [1:0]              dbg_grant,
    output logic                    dbg_pri
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        XFER = 2'd2
    } state_t;

    state_t     state, state_n;
    logic [1:0] grant, grant_n;   // one-hot {g1,g0}
    logic       pri, pri_n;       // requester preferred when both request
    logic       granted_req;
    logic       beat_ok;

    assign granted_req = (grant[0] & req0) | (grant[1] & req1);
    assign beat_ok     = tx_rdy & tx_val;

`ifdef WB_TLC_TX_ARB_WDT_EN
    localparam int WDT_W = (c_WDT_CYCLES > 2) ? $clog2(c_WDT_CYCLES) : 1;
    logic [WDT_W-1:0] wdt_cnt, wdt_n;
    logic             err_n;
`else
    // The limit has no meaning without the watchdog.
    localparam int unused_wdt_cycles = c_WDT_CYCLES;
`endif

    always_comb begin
        state_n = state;
        grant_n = grant;
        pri_n   = pri;
`ifdef WB_TLC_TX_ARB_WDT_EN
        wdt_n   = wdt_cnt;
        err_n   = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (req0 | req1) begin
                    state_n = REQ;
                    if (req0 & req1)
                        grant_n = pri ? 2'b10 : 2'b01;
                    else
                        grant_n = req1 ? 2'b10 : 2'b01;
                end
            end
            REQ: begin
                // A beat taken in the same cycle the request drops still starts the packet.
                if (tx_val) begin
                    if (tx_rdy) begin
                        state_n = XFER;
`ifdef WB_TLC_TX_ARB_WDT_EN
                        wdt_n   = '0;
`endif
                    end else if (!granted_req) begin
                        state_n = IDLE;
                        grant_n = 2'b00;
                    end
                end
            end
            XFER: begin
                if (tx_val) begin
                    if (tx_end) begin
                        state_n = IDLE;
                        grant_n = 2'b00;
                        pri_n   = grant[0];
                    end
`ifdef WB_TLC_TX_ARB_WDT_EN
                    else if (wdt_cnt == WDT_W'(c_WDT_CYCLES - 1)) begin
                        state_n = IDLE;
                        grant_n = 2'b00;
                        pri_n   = ~pri;
                        wdt_n   = '0;
                        err_n   = 1'b1;
                    end else begin
                        wdt_n   = wdt_cnt + WDT_W'(1);
                    end
`endif
                end
            end
            default: begin
                state_n = IDLE;
                grant_n = 2'b00;
            end
        endcase
    end

    always_ff @(posedge clk_125 or negedge rstn) begin
        if (!rstn) begin
            state  <= IDLE;
            grant  <= 2'b00;
            pri    <= 1'b0;
            tx_req <= 1'b0;
        end else begin
            state  <= state_n;
            grant  <= grant_n;
            pri    <= pri_n;
            tx_req <= (state_n == REQ);
        end
    end

`ifdef WB_TLC_TX_ARB_WDT_EN
    always_ff @(posedge clk_125 or negedge rstn) begin
        if (!rstn) begin
            wdt_cnt <= '0;
            arb_err <= 1'b0;
        end else begin
            wdt_cnt <= wdt_n;
            arb_err <= err_n;
        end
    end
`else
    assign arb_err = 1'b0;
`endif

    always_comb begin
        tx_data = '0;
        tx_st   = 1'b0;
        tx_end  = 1'b0;
        tx_dwen = 1'b0;
        if (grant[0]) begin
            tx_data = data0;
            tx_st   = st0;
            tx_end  = end0;
            tx_dwen = dwen0;
        end else if (grant[1]) begin
            tx_data = data1;
            tx_st   = st1;
            tx_end  = end1;
            tx_dwen = dwen1;
        end
    end

    assign rdy0 = beat_ok & grant[0] & (state != IDLE);
    assign rdy1 = beat_ok & grant[1] & (state != IDLE);

    assign dbg_state = state;
    assign dbg_grant = grant;
    assign dbg_pri   = pri;

endmodule

// File: tb/tb_wb_tlc_tx_arb.sv
// Directed bench for wb_tlc_tx_arb: handshake, alternation, freeze, request drop, reset and watchdog cases.
module tb_wb_tlc_tx_arb;

    localparam int DW = 64;
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_XFER = 2'd2;

    logic          clk_125 = 1'b0;
    logic          rstn;
    logic          req0, req1;
    logic [DW-1:0] data0, data1;
    logic          st0, st1, end0, end1, dwen0, dwen1;
    logic          rdy0, rdy1, tx_req, tx_rdy, tx_val;
    logic [DW-1:0] tx_data;
    logic          tx_st, tx_end, tx_dwen, arb_err;
    logic [1:0]    dbg_state, dbg_grant;
    logic          dbg_pri;

    int total = 0;
    int bad   = 0;

    always #5 clk_125 = ~clk_125;

    wb_tlc_tx_arb #(.c_DATA_WIDTH(DW), .c_WDT_CYCLES(16)) dut (
        .clk_125(clk_125), .rstn(rstn),
        .req0(req0), .req1(req1), .data0(data0), .data1(data1),
        .st0(st0), .st1(st1), .end0(end0), .end1(end1), .dwen0(dwen0), .dwen1(dwen1),
        .rdy0(rdy0), .rdy1(rdy1), .tx_req(tx_req), .tx_rdy(tx_rdy), .tx_val(tx_val),
        .tx_data(tx_data), .tx_st(tx_st), .tx_end(tx_end), .tx_dwen(tx_dwen),
        .arb_err(arb_err), .dbg_state(dbg_state), .dbg_grant(dbg_grant), .dbg_pri(dbg_pri)
    );

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_125);
        #1;
    endtask

    task automatic clear_inputs();
        req0 = 0; req1 = 0; data0 = '0; data1 = '0;
        st0 = 0; st1 = 0; end0 = 0; end1 = 0; dwen0 = 0; dwen1 = 0;
        tx_rdy = 0; tx_val = 0;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        clear_inputs();
        tick();
        rstn = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rstn = 1'b0;
        clear_inputs();
        // Active requester while reset is held: every output stays 0.
        req0 = 1; data0 = 64'hDEAD_BEEF; st0 = 1; tx_rdy = 1; tx_val = 1;
        #3;
        chk("rst_state", dbg_state, S_IDLE);
        chk("rst_grant", dbg_grant, 2'b00);
        chk("rst_pri", dbg_pri, 0);
        chk("rst_tx_req", tx_req, 0);
        chk("rst_arb_err", arb_err, 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_rdy0", rdy0, 0);
        tick();
        tick();
        clear_inputs();
        rstn = 1'b1;

        // Basic handshake with requester 0.
        req0 = 1; data0 = 64'hA0; st0 = 1; tx_val = 1; tx_rdy = 0;
        tick();
        chk("b_tx_req", tx_req, 1);
        chk("b_state_req", dbg_state, S_REQ);
        chk("b_rdy0_wait", rdy0, 0);
        tx_rdy = 1;
        #1;
        chk("b_rdy0", rdy0, 1);
        chk("b_rdy1", rdy1, 0);
        chk("b_data", tx_data, 64'hA0);
        chk("b_st", tx_st, 1);
        tick();
        chk("b_state_xfer", dbg_state, S_XFER);
        chk("b_tx_req_low", tx_req, 0);
        st0 = 0; data0 = 64'hA1; end0 = 1; dwen0 = 1; req0 = 0;
        #1;
        chk("b_data2", tx_data, 64'hA1);
        chk("b_end", tx_end, 1);
        chk("b_dwen", tx_dwen, 1);
        tick();
        chk("b_state_idle", dbg_state, S_IDLE);
        chk("b_grant_clr", dbg_grant, 2'b00);
        chk("b_pri", dbg_pri, 1);
        chk("b_data_zero", tx_data, 0);

        // Both requesting with 3-beat packets: grants alternate with one IDLE between.
        do_reset();
        req0 = 1; req1 = 1; data0 = 64'h1111; data1 = 64'h2222; tx_rdy = 1; tx_val = 1;
        for (int p = 0; p < 4; p++) begin
            st0 = 1; st1 = 1; end0 = 0; end1 = 0;
            tick();
            chk("alt_grant", dbg_grant, (p % 2 == 0) ? 2'b01 : 2'b10);
            chk("alt_state_req", dbg_state, S_REQ);
            chk("alt_data", tx_data, (p % 2 == 0) ? 64'h1111 : 64'h2222);
            chk("alt_st", tx_st, 1);
            tick();
            st0 = 0; st1 = 0;
            #1;
            chk("alt_state_xfer", dbg_state, S_XFER);
            tick();
            end0 = 1; end1 = 1;
            #1;
            chk("alt_end", tx_end, 1);
            tick();
            chk("alt_idle", dbg_state, S_IDLE);
            chk("alt_idle_data", tx_data, 0);
            chk("alt_idle_rdy", {rdy1, rdy0}, 2'b00);
            chk("alt_pri", dbg_pri, (p % 2 == 0) ? 1 : 0);
        end

        // Requester 1 asserts mid-packet of requester 0.
        do_reset();
        req0 = 1; data0 = 64'hA0; st0 = 1; tx_rdy = 1; tx_val = 1;
        tick();
        chk("mid_grant0", dbg_grant, 2'b01);
        tick();
        st0 = 0; data0 = 64'hA1;
        req1 = 1; data1 = 64'hB0; st1 = 1; end1 = 1; dwen1 = 1;
        #1;
        chk("mid_data", tx_data, 64'hA1);
        chk("mid_st", tx_st, 0);
        chk("mid_end", tx_end, 0);
        chk("mid_rdy1", rdy1, 0);
        chk("mid_rdy0", rdy0, 1);
        tick();
        end0 = 1; data0 = 64'hA2; req0 = 0;
        #1;
        chk("mid_data_last", tx_data, 64'hA2);
        tick();
        chk("mid_idle", dbg_state, S_IDLE);
        chk("mid_pri", dbg_pri, 1);
        tick();
        chk("mid_grant1", dbg_grant, 2'b10);
        chk("mid_data1", tx_data, 64'hB0);
        chk("mid_rdy1_now", rdy1, 1);

        // tx_val low freezes XFER, even with tx_end presented.
        do_reset();
        req0 = 1; data0 = 64'hC0; tx_rdy = 1; tx_val = 1;
        tick();
        tick();
        chk("frz_xfer", dbg_state, S_XFER);
        tx_val = 0; end0 = 1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("frz_state", dbg_state, S_XFER);
            chk("frz_grant", dbg_grant, 2'b01);
            chk("frz_rdy0", rdy0, 0);
            chk("frz_data", tx_data, 64'hC0);
        end
        chk("frz_pri", dbg_pri, 0);
        tx_val = 1;
        tick();
        chk("frz_done", dbg_state, S_IDLE);
        chk("frz_pri_after", dbg_pri, 1);

        // Request withdrawn in REQ before the core is ready.
        do_reset();
        req0 = 1; tx_rdy = 0; tx_val = 1;
        tick();
        chk("drop_req", dbg_state, S_REQ);
        req0 = 0;
        tick();
        chk("drop_idle", dbg_state, S_IDLE);
        chk("drop_tx_req", tx_req, 0);
        chk("drop_pri", dbg_pri, 0);
        chk("drop_grant", dbg_grant, 2'b00);

        // Asynchronous reset mid-packet.
        do_reset();
        req0 = 1; data0 = 64'hE0; tx_rdy = 1; tx_val = 1;
        tick();
        tick();
        #2;
        rstn = 0;
        #1;
        chk("arst_state", dbg_state, S_IDLE);
        chk("arst_data", tx_data, 0);
        chk("arst_rdy0", rdy0, 0);
        chk("arst_grant", dbg_grant, 2'b00);

        // Packet that never ends.
        do_reset();
        req0 = 1; data0 = 64'hF0; tx_rdy = 1; tx_val = 1;
        tick();
        tick();
        chk("wdt_enter", dbg_state, S_XFER);
`ifdef WB_TLC_TX_ARB_WDT_EN
        for (int i = 0; i < 15; i++) begin
            tick();
            chk("wdt_hold", dbg_state, S_XFER);
            chk("wdt_no_err", arb_err, 0);
        end
        tick();
        chk("wdt_abort_state", dbg_state, S_IDLE);
        chk("wdt_err", arb_err, 1);
        chk("wdt_pri", dbg_pri, 1);
        chk("wdt_grant", dbg_grant, 2'b00);
        req0 = 0;
        tick();
        chk("wdt_err_pulse", arb_err, 0);
`else
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("nowdt_state", dbg_state, S_XFER);
            chk("nowdt_err", arb_err, 0);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
